// File: rtl/pmp_pkg.sv
// Shared PMP definitions: access-size encodings, address/compare widths and a
// size-to-byte-count helper.
package pmp_pkg;

  localparam int unsigned PMP_AW = 32;
  localparam int unsigned PMP_CW = 36;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'b00,
    SZ_HALF  = 2'b01,
    SZ_WORD  = 2'b10,
    SZ_DWORD = 2'b11
  } size_e;

  // Byte count of an access, widened to the compare width so sums never wrap.
  function automatic logic [PMP_CW-1:0] size_bytes(input logic [1:0] sz);
    return PMP_CW'(1) << sz;
  endfunction

endpackage

// File: rtl/napot_decode.sv
// Combinational NAPOT region decode: trailing-ones count, base with those
// ones cleared, and region length 2^(k+3) in compare width.
module napot_decode
  import pmp_pkg::*;
(
  input  logic [PMP_AW-1:0] addr_n,
  output logic [5:0]        k,
  output logic [PMP_AW-1:0] base,
  output logic [PMP_CW-1:0] len
);

  logic              stop;
  logic [PMP_AW-1:0] ones_mask;

  always_comb begin
    k    = '0;
    stop = 1'b0;
    for (int unsigned i = 0; i < PMP_AW; i++) begin
      if (!stop) begin
        if (addr_n[i]) k = k + 6'd1;
        else           stop = 1'b1;
      end
    end
  end

  // A shift by the full width yields zero, so k=32 produces an all-ones mask.
  assign ones_mask = ~({PMP_AW{1'b1}} << k);
  assign base      = addr_n & ~ones_mask;
  assign len       = PMP_CW'(1) << (k + 6'd3);

endmodule

// File: rtl/napot_match.sv
// Registered NAPOT range match: flags, one cycle later, whether every byte of
// the access at addr/size lies inside the region encoded by addr_n.
module napot_match
  import pmp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [PMP_AW-1:0] addr,
  input  logic [PMP_AW-1:0] addr_n,
  input  logic [1:0]        size,
  output logic              napot_out
);

  logic [5:0]        k;
  logic [PMP_AW-1:0] base;
  logic [PMP_CW-1:0] len;
  logic [PMP_CW-1:0] acc_lo, acc_end;
  logic [PMP_CW-1:0] reg_lo, reg_end;
  logic              lo_ok, hi_ok, match_d;
  logic              match_q;

  napot_decode u_decode (
    .addr_n (addr_n),
    .k      (k),
    .base   (base),
    .len    (len)
  );

  assign acc_lo  = PMP_CW'(addr);
  assign acc_end = acc_lo + size_bytes(size);
  assign reg_lo  = PMP_CW'(base);
  assign reg_end = reg_lo + len;

  assign lo_ok = acc_lo >= reg_lo;
  assign hi_ok = acc_end <= reg_end;

  // k=32 spans 2^35 bytes, which already covers any access; the comparators
  // agree, this just makes the full-space case explicit.
  always_comb begin
    match_d = lo_ok && hi_ok;
    if (k == 6'd32) match_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match_d;
  end

  assign napot_out = match_q;

endmodule

// File: tb/tb_napot_match.sv
// Directed and randomized checks of napot_match with a queue scoreboard and a
// one-cycle-latency compare after every stimulus edge.
module tb_napot_match;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] addr_n;
  logic [1:0]  size;
  logic        napot_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic  exp_q[$];
  string tag_q[$];

  napot_match dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .addr_n    (addr_n),
    .size      (size),
    .napot_out (napot_out)
  );

  always #5 clk = ~clk;

  // Independent reference: wide integer arithmetic, base by shift-down/up.
  function automatic logic model(input logic [31:0] an, input logic [31:0] a,
                                 input logic [1:0] sz);
    int unsigned   kk;
    longint unsigned b, l, lo, hi;
    kk = 0;
    while (kk < 32 && an[kk]) kk++;
    b  = (kk == 32) ? 64'd0 : longint'((an >> kk) << kk);
    l  = 64'd8 << kk;
    lo = longint'(a);
    hi = lo + (64'd1 << sz);
    return (lo >= b) && (hi <= b + l);
  endfunction

  task automatic step(input logic r, input logic [31:0] an, input logic [31:0] a,
                      input logic [1:0] sz, input logic e, input string tag);
    logic  exp_v;
    string tag_v;
    @(negedge clk);
    rst    = r;
    addr_n = an;
    addr   = a;
    size   = sz;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end else begin
      exp_v = exp_q.pop_front();
      tag_v = tag_q.pop_front();
      assert (napot_out === exp_v) else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b (addr_n=%h addr=%h size=%0d)",
               tag_v, napot_out, exp_v, an, a, sz);
      end
    end
  endtask

  initial begin
    logic [31:0] an, a;
    logic [1:0]  sz;
    rst = 1'b1; addr = '0; addr_n = '0; size = '0;

    step(1'b1, 32'hFFFF_FFFF, 32'h0, 2'b11, 1'b0, "reset_hold");
    step(1'b1, 32'hFFFF_FFFF, 32'h0, 2'b11, 1'b0, "reset_hold2");
    step(1'b0, 32'hFFFF_FFFF, 32'h0, 2'b11, 1'b1, "reset_release");

    for (int i = 0; i < 4; i++)
      step(1'b0, 32'h1234_567E, 32'h1234_567D, 2'(i), 1'b0, "k0_below");
    step(1'b0, 32'h1234_567E, 32'h1234_567E, 2'b00, 1'b1, "k0_base_b");
    step(1'b0, 32'h1234_567E, 32'h1234_567E, 2'b01, 1'b1, "k0_base_h");
    step(1'b0, 32'h1234_567E, 32'h1234_567E, 2'b11, 1'b1, "k0_base_d");
    step(1'b0, 32'h1234_567E, 32'h1234_5683, 2'b01, 1'b1, "k0_mid_h");
    step(1'b0, 32'h1234_567E, 32'h1234_5683, 2'b11, 1'b0, "k0_mid_d_over");
    step(1'b0, 32'h1234_567E, 32'h1234_5685, 2'b00, 1'b1, "k0_last_b");
    step(1'b0, 32'h1234_567E, 32'h1234_5685, 2'b01, 1'b0, "k0_last_h_over");

    step(1'b0, 32'h1234_567D, 32'h1234_567B, 2'b00, 1'b0, "k1_below");
    step(1'b0, 32'h1234_567D, 32'h1234_567C, 2'b11, 1'b1, "k1_base_d");
    step(1'b0, 32'h1234_567D, 32'h1234_568B, 2'b00, 1'b1, "k1_last_b");
    step(1'b0, 32'h1234_567D, 32'h1234_568B, 2'b01, 1'b0, "k1_last_h_over");

    step(1'b0, 32'h1234_567B, 32'h1234_5678 + 32'd31, 2'b00, 1'b1, "k2_last_b");
    step(1'b0, 32'h1234_567B, 32'h1234_5678 + 32'd31, 2'b01, 1'b0, "k2_last_h_over");
    step(1'b0, 32'h1234_566F, 32'h1234_5660 + 32'd127, 2'b00, 1'b1, "k4_last_b");
    step(1'b0, 32'h1234_566F, 32'h1234_5660 + 32'd127, 2'b01, 1'b0, "k4_last_h_over");

    step(1'b0, 32'h0, 32'hFFFF_FFFF, 2'b00, 1'b0, "zero_nowrap");
    step(1'b0, 32'h0, 32'h0, 2'b11, 1'b1, "zero_base_d");
    step(1'b0, 32'h0, 32'h7, 2'b00, 1'b1, "zero_last_b");
    step(1'b0, 32'h0, 32'h7, 2'b01, 1'b0, "zero_last_h_over");

    step(1'b0, 32'hFFFF_FFFF, 32'h0, 2'b11, 1'b1, "all_lo_d");
    step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 2'b11, 1'b1, "all_top_d");
    step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b1, "all_end_b");
    step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 1'b1, "all_end_h");
    step(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 1'b1, "all_end_d");

    // Mid-stream reset drops the in-flight result, then matching resumes.
    step(1'b1, 32'hFFFF_FFFF, 32'h10, 2'b10, 1'b0, "midreset");
    step(1'b0, 32'hFFFF_FFFF, 32'h10, 2'b10, 1'b1, "midreset_resume");

    for (int i = 0; i < 40; i++) begin
      an = $urandom | ((32'd1 << $urandom_range(0, 10)) - 32'd1);
      a  = an + $urandom_range(0, 64) - 32'd40;
      sz = 2'($urandom_range(0, 3));
      step(1'b0, an, a, sz, model(an, a, sz), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
